// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// Serves 32-bit word accesses from the core and moves 128-bit lines to and from slow memory.
// Every miss stalls the core until the line has been written back (if dirty) and refilled.
module dcache_wb #(
  parameter int unsigned NUM_BLOCK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int unsigned IDX_W = $clog2(NUM_BLOCK);
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StAllocate
  } state_e;

  state_e state_q, state_d;

  logic [NUM_BLOCK-1:0] valid_q;
  logic [NUM_BLOCK-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_BLOCK];
  logic [127:0]         data_q [NUM_BLOCK];

  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             req;
  logic             is_read;
  logic             hit;
  logic [127:0]     line;
  logic [6:0]       word_lsb;
  logic             wr_hit;
  logic             refill;

  assign off      = proc_addr[1:0];
  assign idx      = proc_addr[IDX_W+1:2];
  assign req_tag  = proc_addr[29:IDX_W+2];
  assign req      = proc_read | proc_write;
  // A simultaneous read and write is treated as a write.
  assign is_read  = proc_read & ~proc_write;
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
  assign line     = data_q[idx];
  assign word_lsb = {off, 5'd0};

  // Next-state and output decode; memory strobes depend on state only.
  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_hit     = 1'b0;
    refill     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            if (is_read) proc_rdata = line[word_lsb +: 32];
            wr_hit = proc_write;
          end else begin
            proc_stall = 1'b1;
            state_d    = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[idx], idx};
        mem_wdata  = line;
        if (mem_ready) state_d = StAllocate;
      end
      StAllocate: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {req_tag, idx};
        if (mem_ready) begin
          refill  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and per-line status bits; reset abandons any transfer and drops dirty data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (refill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q qualifies them.
  always_ff @(posedge clk) begin
    if (refill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= req_tag;
    end else if (wr_hit) begin
      data_q[idx][word_lsb +: 32] <= proc_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: directed scenarios followed by random accesses,
// all checked against a line-level cache/memory model kept in the bench.
module tb_dcache_wb;

  logic         clk;
  logic         rst;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int tests;
  int failed;

  // Reference model: cache contents and backing memory keyed by line address.
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [127:0] m_data  [8];
  logic [127:0] mem_m   [logic [27:0]];

  dcache_wb #(.NUM_BLOCK(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_get(input logic [27:0] la);
    if (mem_m.exists(la)) return mem_m[la];
    return {la, 4'h4, la, 4'h3, la, 4'h2, la, 4'h1};
  endfunction

  // One core access from request to completion, checking every cycle against the model.
  task automatic access(input bit wr, input bit both, input logic [29:0] a,
                        input logic [31:0] wd);
    int          ix;
    int          off;
    logic [24:0] t;
    logic [27:0] wb_la;
    int unsigned lat;
    ix  = int'(a[4:2]);
    off = int'(a[1:0]);
    t   = a[29:5];
    proc_read  = !wr || both;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    @(negedge clk);
    if (!(m_valid[ix] && m_tag[ix] == t)) begin
      chk("miss_stall", 128'(proc_stall), 128'(1));
      chk("miss_idle_mem", 128'({mem_read, mem_write}), 128'(0));
      @(posedge clk); #1;
      if (m_dirty[ix]) begin
        wb_la = {m_tag[ix], 3'(ix)};
        lat   = $urandom_range(0, 3);
        for (int k = 0; k <= int'(lat); k++) begin
          @(negedge clk);
          chk("wb_strobes", 128'({mem_read, mem_write}), 128'(2'b01));
          chk("wb_addr", 128'(mem_addr), 128'(wb_la));
          chk("wb_data", mem_wdata, m_data[ix]);
          chk("wb_stall", 128'(proc_stall), 128'(1));
          if (k == int'(lat)) mem_ready = 1'b1;
          @(posedge clk); #1;
          mem_ready = 1'b0;
        end
        mem_m[wb_la] = m_data[ix];
      end
      lat = $urandom_range(0, 3);
      for (int k = 0; k <= int'(lat); k++) begin
        @(negedge clk);
        chk("alloc_strobes", 128'({mem_read, mem_write}), 128'(2'b10));
        chk("alloc_addr", 128'(mem_addr), 128'(a[29:2]));
        chk("alloc_stall", 128'(proc_stall), 128'(1));
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (k == int'(lat)) begin
          mem_rdata = mem_get(a[29:2]);
          mem_ready = 1'b1;
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
      end
      m_valid[ix] = 1'b1;
      m_dirty[ix] = 1'b0;
      m_tag[ix]   = t;
      m_data[ix]  = mem_get(a[29:2]);
      @(negedge clk);
    end
    chk("hit_stall", 128'(proc_stall), 128'(0));
    chk("hit_rdata", 128'(proc_rdata), wr ? 128'(0) : 128'(m_data[ix][off*32 +: 32]));
    chk("hit_no_mem", 128'({mem_read, mem_write}), 128'(0));
    @(posedge clk); #1;
    if (wr) begin
      m_data[ix][off*32 +: 32] = wd;
      m_dirty[ix] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  initial begin
    tests      = 0;
    failed     = 0;
    rst        = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    model_reset();
    mem_m[28'h1] = 128'h44444444_33333333_22222222_11111111;

    // Reset state, with and without a pending request.
    #2;
    chk("rst_stall", 128'(proc_stall), 128'(0));
    chk("rst_strobes", 128'({mem_read, mem_write}), 128'(0));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_wdata", mem_wdata, 128'(0));
    chk("rst_rdata", 128'(proc_rdata), 128'(0));
    proc_read = 1'b1;
    #1;
    chk("rst_req_stall", 128'(proc_stall), 128'(1));
    proc_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold read miss, read hit, write hit, dirty eviction, clean conflict miss.
    access(1'b0, 1'b0, 30'h5, 32'h0);
    chk("cold_word", 128'(m_data[1][63:32]), 128'(32'h22222222));
    access(1'b0, 1'b0, 30'h4, 32'h0);
    access(1'b1, 1'b0, 30'h5, 32'hDEADBEEF);
    access(1'b0, 1'b0, 30'h25, 32'h0);
    chk("evicted_line", mem_m[28'h1], 128'h44444444_33333333_DEADBEEF_11111111);
    access(1'b0, 1'b0, 30'h5, 32'h0);

    // Idle with a stray mem_ready pulse.
    proc_read  = 1'b0;
    proc_write = 1'b0;
    mem_ready  = 1'b1;
    @(negedge clk);
    chk("idle_stall", 128'(proc_stall), 128'(0));
    chk("idle_strobes", 128'({mem_read, mem_write}), 128'(0));
    chk("idle_addr", 128'(mem_addr), 128'(0));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_ready", 128'({proc_stall, mem_read, mem_write}), 128'(0));
    @(posedge clk); #1;
    access(1'b0, 1'b0, 30'h5, 32'h0);

    // Reset mid-ALLOCATE drops the request without a clock edge.
    proc_read = 1'b1;
    proc_addr = 30'h100;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_read", 128'(mem_read), 128'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_read", 128'({mem_read, mem_write}), 128'(0));
    chk("mid_rst_stall", 128'(proc_stall), 128'(1));
    chk("mid_rst_addr", 128'(mem_addr), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    access(1'b0, 1'b0, 30'h100, 32'h0);
    access(1'b0, 1'b0, 30'h5, 32'h0);

    // Random traffic over a small tag range to mix hits, clean and dirty misses.
    for (int n = 0; n < 300; n++) begin
      logic [29:0] ra;
      bit          rw;
      ra = {23'd0, 2'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)};
      rw = 1'($urandom);
      access(rw, rw && ($urandom_range(0, 3) == 0), ra, $urandom);
      if ($urandom_range(0, 7) == 0) begin
        proc_read  = 1'b0;
        proc_write = 1'b0;
        @(negedge clk);
        chk("rand_idle", 128'({proc_stall, mem_read, mem_write}), 128'(0));
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
